// File: rtl/nrf_spi_if.sv
// Byte-stream and pin bundle between the nRF24L01 SPI master and its surroundings.
// The master modport is the controller's own view; slave is the user/pin-side view.
interface nrf_spi_if;
    logic       spi_tick;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       csn;
    logic       miso;

    modport master (
        input  spi_tick, tx_data, tx_last, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, csn
    );

    modport slave (
        output spi_tick, tx_data, tx_last, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, csn
    );
endinterface

// File: rtl/nrf_spi_master.sv
// SPI mode-0 master for the nRF24L01: byte-streamed frames framed by CSN,
// with all pin timing advanced only on the upstream spi_tick enable.
module nrf_spi_master #(
    parameter int unsigned SETUP_TICKS = 1,
    parameter int unsigned HOLD_TICKS  = 1,
    parameter int unsigned GAP_TICKS   = 2
) (
    input logic       clk,
    input logic       rst,
    nrf_spi_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] SHIFT     = 3'd2;
    localparam logic [2:0] BYTE_WAIT = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    localparam logic [7:0] SETUP_T = 8'(SETUP_TICKS);
    localparam logic [7:0] HOLD_T  = 8'(HOLD_TICKS);
    localparam logic [7:0] GAP_T   = 8'(GAP_TICKS);

    logic [2:0] state;
    logic [7:0] tick_cnt;
    logic [7:0] tick_nxt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       last_q;
    logic       tx_ready;
    logic       hs;
    logic       sclk_q, mosi_q, csn_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, done_q, busy_q;

    assign tx_ready = (state == IDLE) || (state == BYTE_WAIT);
    assign hs       = bus.tx_valid && tx_ready;
    assign tick_nxt = tick_cnt + 8'd1;

    assign bus.tx_ready = tx_ready;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.csn      = csn_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // NOTE: every register here uses <= so all updates of one edge see the
    // pre-edge values; mixing in blocking assignments would reorder the shift/compare logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= 8'd0;
            tx_shift   <= 8'd0;
            rx_shift   <= 8'd0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csn_q      <= 1'b1;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick coinciding with the handshake is deliberately dropped.
                    if (hs) begin
                        tx_shift <= bus.tx_data;
                        last_q   <= bus.tx_last;
                        mosi_q   <= bus.tx_data[7];
                        csn_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        tick_cnt <= 8'd0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.spi_tick) begin
                        if (tick_nxt == SETUP_T) begin
                            tick_cnt <= 8'd0;
                            state    <= SHIFT;
                        end else begin
                            tick_cnt <= tick_nxt;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.spi_tick) begin
                        if (!tick_cnt[0]) begin
                            sclk_q   <= 1'b1;
                            rx_shift <= {rx_shift[6:0], bus.miso};
                            tick_cnt <= tick_nxt;
                        end else begin
                            sclk_q <= 1'b0;
                            if (tick_nxt == 8'd16) begin
                                rx_data_q  <= rx_shift;
                                rx_valid_q <= 1'b1;
                                tick_cnt   <= 8'd0;
                                state      <= last_q ? HOLD : BYTE_WAIT;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                mosi_q   <= tx_shift[6];
                                tick_cnt <= tick_nxt;
                            end
                        end
                    end
                end
                BYTE_WAIT: begin
                    // Next byte goes straight to SHIFT: CSN is already low and settled.
                    if (hs) begin
                        tx_shift <= bus.tx_data;
                        last_q   <= bus.tx_last;
                        mosi_q   <= bus.tx_data[7];
                        tick_cnt <= 8'd0;
                        state    <= SHIFT;
                    end
                end
                HOLD: begin
                    if (bus.spi_tick) begin
                        if (tick_nxt == HOLD_T) begin
                            csn_q    <= 1'b1;
                            tick_cnt <= 8'd0;
                            state    <= GAP;
                        end else begin
                            tick_cnt <= tick_nxt;
                        end
                    end
                end
                GAP: begin
                    if (bus.spi_tick) begin
                        if (tick_nxt == GAP_T) begin
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            tick_cnt <= 8'd0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_nxt;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    csn_q    <= 1'b1;
                    sclk_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    tick_cnt <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nrf_spi_master.sv
// Directed bench for nrf_spi_master: mode-0 slave model on the pins, tick-domain
// statistics sampled on the falling clk edge, inputs driven 2 ns after the rising edge.
module tb_nrf_spi_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nrf_spi_if bus ();

    nrf_spi_master #(.SETUP_TICKS(1), .HOLD_TICKS(1), .GAP_TICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // spi_tick generator: one pulse every tick_div clocks
    int tick_div = 1;
    int div_cnt  = 0;
    initial begin
        bus.spi_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (div_cnt >= tick_div - 1) begin
                div_cnt      = 0;
                bus.spi_tick = 1'b1;
            end else begin
                div_cnt++;
                bus.spi_tick = 1'b0;
            end
        end
    end

    // Mode-0 slave: MSB presented while CSN low, next bit after each SCK fall.
    logic       clr = 1'b0;
    logic [7:0] resp [4];
    logic [2:0] slv_bit;
    logic [1:0] slv_idx;
    logic [7:0] slv_byte;
    logic [31:0] mosi_sr;
    int          rise_cnt = 0;

    assign slv_byte = resp[slv_idx];
    assign bus.miso = slv_byte[~slv_bit];

    always @(negedge bus.sclk or posedge clr) begin
        if (clr) begin
            slv_bit = 3'd0;
            slv_idx = 2'd0;
        end else begin
            if (slv_bit == 3'd7) slv_idx = slv_idx + 2'd1;
            slv_bit = slv_bit + 3'd1;
        end
    end

    always @(posedge bus.sclk or posedge clr) begin
        if (clr) begin
            mosi_sr  = 32'd0;
            rise_cnt = 0;
        end else begin
            mosi_sr = {mosi_sr[30:0], bus.mosi};
            rise_cnt++;
        end
    end

    // Tick-domain statistics; ticks consumed by a handshake or stall (tx_ready high) are excluded.
    int          low_ticks, gap_ticks, rxv_cnt, done_cnt;
    int          ready_err = 0;
    logic [23:0] rx_hist;
    logic [2:0]  pins [$];
    logic [2:0]  pins_a [$];

    always @(negedge clk) begin
        if (bus.tx_ready && (bus.sclk || (bus.csn && bus.busy))) ready_err++;
        if (clr) begin
            low_ticks = 0;
            gap_ticks = 0;
            rxv_cnt   = 0;
            done_cnt  = 0;
            rx_hist   = 24'd0;
            pins.delete();
        end else begin
            if (bus.rx_valid) begin
                rxv_cnt++;
                rx_hist = {rx_hist[15:0], bus.rx_data};
            end
            if (bus.done) done_cnt++;
            if (bus.spi_tick && !bus.csn && !bus.tx_ready) low_ticks++;
            if (bus.spi_tick && bus.csn && bus.busy) gap_ticks++;
            if (bus.spi_tick && bus.busy && !bus.tx_ready) pins.push_back({bus.sclk, bus.mosi, bus.csn});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        while (!bus.tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(bus.tx_ready), 32'd1);
        step();
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        step();
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.rx_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rx_seen"}, 32'(bus.rx_valid), 32'd1);
        step();
    endtask

    initial begin
        int n;
        int diff;
        int r0;
        int bad;
        int t;

        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int diff;
        int r0;
        int bad;
        int t;

        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        for (int i = 0; i < 4; i++) resp[i] = 8'h00;
        repeat (3) step();

        // Reset state
        check("rst_csn",      32'(bus.csn),      32'd1);
        check("rst_sclk",     32'(bus.sclk),     32'd0);
        check("rst_mosi",     32'(bus.mosi),     32'd0);
        check("rst_rx_data",  32'(bus.rx_data),  32'h00);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        rst = 1'b0;
        step();

        // Single byte 0xA5, slave answers 0x3C, tick every clk
        tick_div = 1;
        resp[0]  = 8'h3C;
        clear_stats();
        send(8'hA5, 1'b1);
        wait_done("b1");
        check("b1_mosi",      mosi_sr[7:0],   32'hA5);
        check("b1_rises",     32'(rise_cnt),  32'd8);
        check("b1_rx_data",   32'(rx_hist[7:0]), 32'h3C);
        check("b1_rx_pulses", 32'(rxv_cnt),   32'd1);
        check("b1_csn_low",   32'(low_ticks), 32'd18);
        check("b1_gap",       32'(gap_ticks), 32'd2);
        check("b1_done_cnt",  32'(done_cnt),  32'd1);
        check("b1_csn_idle",  32'(bus.csn),   32'd1);
        pins_a = pins;

        // Same byte with spi_tick every 5th clk: identical tick-domain pin sequence
        tick_div = 5;
        clear_stats();
        send(8'hA5, 1'b1);
        wait_done("b5");
        check("b5_rx_data",   32'(rx_hist[7:0]), 32'h3C);
        check("pins_len_max", 32'(pins_a.size()), 32'd20);
        check("pins_len_div5", 32'(pins.size()), 32'd20);
        diff = 0;
        for (int i = 0; i < pins.size() && i < pins_a.size(); i++)
            if (pins[i] !== pins_a[i]) diff++;
        check("pins_equal",   32'(diff),      32'd0);
        check("pins_first",   32'(pins_a[0]), 32'h2);
        check("pins_last",    32'(pins_a[19]), 32'h3);

        // Three-byte back-to-back frame
        tick_div = 3;
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
        clear_stats();
        send(8'h20, 1'b0);
        send(8'h0F, 1'b0);
        send(8'hE7, 1'b1);
        wait_done("f3");
        check("f3_mosi",      mosi_sr[23:0],  32'h200FE7);
        check("f3_rx",        32'(rx_hist),   32'h112233);
        check("f3_rx_pulses", 32'(rxv_cnt),   32'd3);
        check("f3_csn_low",   32'(low_ticks), 32'd50);
        check("f3_done_cnt",  32'(done_cnt),  32'd1);

        // Stall for 40 ticks in BYTE_WAIT
        tick_div = 2;
        resp[0] = 8'h96; resp[1] = 8'h69;
        clear_stats();
        send(8'h5A, 1'b0);
        wait_rx("st");
        r0  = rise_cnt;
        bad = 0;
        t   = 0;
        while (t < 40) begin
            @(negedge clk);
            if (bus.spi_tick) t++;
            if (bus.sclk !== 1'b0 || bus.csn !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
        end
        step();
        check("st_pins_quiet", 32'(bad),      32'd0);
        check("st_no_edges",   32'(rise_cnt), 32'(r0));
        send(8'hC3, 1'b1);
        wait_done("st");
        check("st_mosi",      mosi_sr[15:0],  32'h5AC3);
        check("st_rx",        32'(rx_hist[15:0]), 32'h9669);
        check("st_csn_low",   32'(low_ticks), 32'd34);
        check("st_done_cnt",  32'(done_cnt),  32'd1);

        // Reset after tick 7 of byte 2
        tick_div = 1;
        resp[0] = 8'hF0; resp[1] = 8'h0F;
        clear_stats();
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        n = 0;
        @(negedge clk);
        while (rise_cnt < 12 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ab_pre_sclk", 32'(bus.sclk), 32'd1);
        rst = 1'b1;
        #1;
        check("ab_csn",      32'(bus.csn),      32'd1);
        check("ab_sclk",     32'(bus.sclk),     32'd0);
        check("ab_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("ab_busy",     32'(bus.busy),     32'd0);
        repeat (3) step();
        check("ab_no_done",  32'(done_cnt),     32'd0);
        check("ab_rx_pulses", 32'(rxv_cnt),     32'd1);
        check("ab_rx_byte1", 32'(rx_hist[7:0]), 32'hF0);
        rst = 1'b0;
        step();
        resp[0] = 8'hE1;
        clear_stats();
        send(8'h77, 1'b1);
        wait_done("ar");
        check("ar_mosi",     mosi_sr[7:0],   32'h77);
        check("ar_rx",       32'(rx_hist[7:0]), 32'hE1);
        check("ar_csn_low",  32'(low_ticks), 32'd18);
        check("ar_done_cnt", 32'(done_cnt),  32'd1);

        // tx_valid raised during GAP: accepted only once IDLE is reached
        tick_div = 2;
        resp[0] = 8'h4B; resp[1] = 8'hD2;
        clear_stats();
        send(8'h55, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(bus.csn && bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("gp_in_gap", 32'(bus.csn && bus.busy), 32'd1);
        bus.tx_data  = 8'h81;
        bus.tx_last  = 1'b1;
        bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("gp_ready",     32'(bus.tx_ready), 32'd1);
        check("gp_csn_high",  32'(bus.csn),      32'd1);
        check("gp_gap_ticks", 32'(gap_ticks),    32'd2);
        step();
        bus.tx_valid = 1'b0;
        check("gp_done_first", 32'(done_cnt),    32'd1);
        wait_done("gp");
        check("gp_mosi",      mosi_sr[15:0],  32'h5581);
        check("gp_rx",        32'(rx_hist[15:0]), 32'h4BD2);
        check("gp_done_cnt",  32'(done_cnt),  32'd2);

        check("tx_ready_states", 32'(ready_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
